// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory port B arbiter: access sizes, FSM encodings, address width.
package dmem_pkg;

  localparam int DMEM_AW = 10;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic [0:0] ST_CPU_PRI = 1'b0;
  localparam logic [0:0] ST_LDR_PRI = 1'b1;

endpackage

// File: rtl/dmem_port_arb_if.sv
// Bundle of the CPU, loader and BRAM port B signals around the arbiter.
// slave is the arbiter's view; master is the requester/BRAM environment's view.
interface dmem_port_arb_if import dmem_pkg::*; #(parameter int AW = DMEM_AW);

  logic          c_req;
  logic          c_we;
  logic          c_size;
  logic [AW-1:0] c_addr;
  logic [15:0]   c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [15:0]   c_rdata;
  logic          c_err;

  logic          l_req;
  logic          l_we;
  logic          l_size;
  logic [AW-1:0] l_addr;
  logic [15:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [15:0]   l_rdata;
  logic          l_err;

  logic          b_en;
  logic          b_we_h;
  logic          b_we_l;
  logic [AW-2:0] b_addr;
  logic [7:0]    b_din_h;
  logic [7:0]    b_din_l;
  logic [7:0]    b_dout_h;
  logic [7:0]    b_dout_l;

  modport slave (
    input  c_req, c_we, c_size, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  l_req, l_we, l_size, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output b_en, b_we_h, b_we_l, b_addr, b_din_h, b_din_l,
    input  b_dout_h, b_dout_l
  );

  modport master (
    output c_req, c_we, c_size, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output l_req, l_we, l_size, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  b_en, b_we_h, b_we_l, b_addr, b_din_h, b_din_l,
    output b_dout_h, b_dout_l
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Big-endian byte-lane mapper: request fields to lane enables/data, and registered
// lane data back to aligned read data (even byte lives in the high lane).
module dmem_lane_fmt import dmem_pkg::*; (
  input  logic        we,
  input  logic        size,
  input  logic        a0,
  input  logic [15:0] wdata,
  output logic        we_h,
  output logic        we_l,
  output logic [7:0]  din_h,
  output logic [7:0]  din_l,
  output logic        misaligned,
  input  logic        rd_size,
  input  logic        rd_a0,
  input  logic [7:0]  dout_h,
  input  logic [7:0]  dout_l,
  output logic [15:0] rdata
);

  always_comb begin
    misaligned = (size == SIZE_WORD) && a0;
    if (size == SIZE_WORD) begin
      din_h = wdata[15:8];
      din_l = wdata[7:0];
      we_h  = we && !a0;
      we_l  = we && !a0;
    end else begin
      din_h = wdata[7:0];
      din_l = wdata[7:0];
      we_h  = we && !a0;
      we_l  = we && a0;
    end
  end

  always_comb begin
    if (rd_size == SIZE_WORD) rdata = {dout_h, dout_l};
    else                      rdata = {8'h00, rd_a0 ? dout_l : dout_h};
  end

endmodule

// File: rtl/dmem_port_arb.sv
// Port B arbiter/sequencer: CPU normally wins, the loader is promoted after STARVE_MAX denials.
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_port_arb import dmem_pkg::*; #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = DMEM_AW
) (
  input  logic clk,
  input  logic rst,
  dmem_port_arb_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_c_grants,
  output logic [15:0] stat_l_grants,
  output logic [15:0] stat_conflicts
`endif
);

  logic [0:0]    state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic          c_win, l_win, any_gnt;
  logic          w_we, w_size;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_wdata;
  logic          fmt_we_h, fmt_we_l, misaligned;
  logic [7:0]    fmt_din_h, fmt_din_l;
  logic          resp_v_q, resp_own_q, resp_we_q, resp_size_q, resp_a0_q, resp_mis_q;
  logic          resp_live;
  logic [15:0]   rd_data, load_data;

  // Reset gates grants immediately so nothing reaches the BRAM during rst.
  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
    if (!rst) begin
      if (state_q == ST_CPU_PRI) begin
        if (bus.c_req)      c_win = 1'b1;
        else if (bus.l_req) l_win = 1'b1;
      end else begin
        if (bus.l_req)      l_win = 1'b1;
        else if (bus.c_req) c_win = 1'b1;
      end
    end
  end

  assign any_gnt   = c_win || l_win;
  assign bus.c_gnt = c_win;
  assign bus.l_gnt = l_win;

  assign w_we    = l_win ? bus.l_we    : bus.c_we;
  assign w_size  = l_win ? bus.l_size  : bus.c_size;
  assign w_addr  = l_win ? bus.l_addr  : bus.c_addr;
  assign w_wdata = l_win ? bus.l_wdata : bus.c_wdata;

  dmem_lane_fmt u_fmt (
    .we         (w_we),
    .size       (w_size),
    .a0         (w_addr[0]),
    .wdata      (w_wdata),
    .we_h       (fmt_we_h),
    .we_l       (fmt_we_l),
    .din_h      (fmt_din_h),
    .din_l      (fmt_din_l),
    .misaligned (misaligned),
    .rd_size    (resp_size_q),
    .rd_a0      (resp_a0_q),
    .dout_h     (bus.b_dout_h),
    .dout_l     (bus.b_dout_l),
    .rdata      (rd_data)
  );

  assign bus.b_en    = any_gnt && !misaligned;
  assign bus.b_we_h  = bus.b_en && fmt_we_h;
  assign bus.b_we_l  = bus.b_en && fmt_we_l;
  assign bus.b_addr  = w_addr[AW-1:1];
  assign bus.b_din_h = fmt_din_h;
  assign bus.b_din_l = fmt_din_l;

  // Promotion is decided on the updated count so L wins right after its STARVE_MAX-th denial.
  always_comb begin
    wait_d  = wait_q;
    state_d = state_q;
    if (!bus.l_req || l_win)           wait_d = 4'd0;
    else if (wait_q < 4'(STARVE_MAX))  wait_d = wait_q + 4'd1;
    case (state_q)
      ST_CPU_PRI: if (wait_d == 4'(STARVE_MAX)) state_d = ST_LDR_PRI;
      default:    if (l_win || !bus.l_req)      state_d = ST_CPU_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CPU_PRI;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_v_q    <= 1'b0;
      resp_own_q  <= 1'b0;
      resp_we_q   <= 1'b0;
      resp_size_q <= SIZE_BYTE;
      resp_a0_q   <= 1'b0;
      resp_mis_q  <= 1'b0;
    end else begin
      resp_v_q    <= any_gnt;
      resp_own_q  <= l_win;
      resp_we_q   <= w_we;
      resp_size_q <= w_size;
      resp_a0_q   <= w_addr[0];
      resp_mis_q  <= misaligned;
    end
  end

  // A response registered just before rst rises is dropped rather than presented.
  assign resp_live = resp_v_q && !rst;
  assign load_data = resp_mis_q ? 16'h0000 : rd_data;

  assign bus.c_rvalid = resp_live && !resp_own_q && !resp_we_q;
  assign bus.c_err    = resp_live && !resp_own_q && resp_mis_q;
  assign bus.c_rdata  = bus.c_rvalid ? load_data : 16'h0000;

  assign bus.l_rvalid = resp_live && resp_own_q && !resp_we_q;
  assign bus.l_err    = resp_live && resp_own_q && resp_mis_q;
  assign bus.l_rdata  = bus.l_rvalid ? load_data : 16'h0000;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cnt_c, cnt_l, cnt_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_c <= 16'h0000;
      cnt_l <= 16'h0000;
      cnt_x <= 16'h0000;
    end else begin
      if (c_win && cnt_c != 16'hFFFF)                   cnt_c <= cnt_c + 16'd1;
      if (l_win && cnt_l != 16'hFFFF)                   cnt_l <= cnt_l + 16'd1;
      if (bus.c_req && bus.l_req && cnt_x != 16'hFFFF)  cnt_x <= cnt_x + 16'd1;
    end
  end

  assign stat_c_grants  = cnt_c;
  assign stat_l_grants  = cnt_l;
  assign stat_conflicts = cnt_x;
`endif

endmodule

// File: tb/tb_dmem_port_arb.sv
// Scoreboard bench for dmem_port_arb with a byte-lane BRAM model on port B.
module tb_dmem_port_arb;
  import dmem_pkg::*;

  localparam int STARVE = 4;

  typedef struct {
    int          due;
    bit          is_l;
    bit          rvalid;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  logic [7:0] mem_h [512] = '{default: 8'h00};
  logic [7:0] mem_l [512] = '{default: 8'h00};

  dmem_port_arb_if #(.AW(DMEM_AW)) bus();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_c_grants, stat_l_grants, stat_conflicts;
  logic [15:0] snap_c, snap_l, snap_x;
`endif

  dmem_port_arb #(.STARVE_MAX(STARVE), .AW(DMEM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_c_grants  (stat_c_grants),
    .stat_l_grants  (stat_l_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read BRAM: write lands at the edge, so a read one cycle later sees it.
  always @(posedge clk) begin
    if (bus.b_en) begin
      if (bus.b_we_h) mem_h[bus.b_addr] <= bus.b_din_h;
      if (bus.b_we_l) mem_l[bus.b_addr] <= bus.b_din_l;
      bus.b_dout_h <= mem_h[bus.b_addr];
      bus.b_dout_l <= mem_l[bus.b_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit is_l, input logic req, input logic we, input logic size,
                               input logic [9:0] addr, input logic [15:0] wdata);
    if (is_l) begin
      bus.l_req = req; bus.l_we = we; bus.l_size = size; bus.l_addr = addr; bus.l_wdata = wdata;
    end else begin
      bus.c_req = req; bus.c_we = we; bus.c_size = size; bus.c_addr = addr; bus.c_wdata = wdata;
    end
  endtask

  task automatic expectResp(input bit is_l, input bit rvalid, input bit err, input logic [15:0] rdata);
    exp_t e;
    e.due = cyc + 1; e.is_l = is_l; e.rvalid = rvalid; e.err = err; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Both requesters hold requests; L wins once every STARVE+1 cycles starting from a fresh counter.
  task automatic conflictCycles(input int n, input bit push_last);
    bit exp_l;
    for (int k = 0; k < n; k++) begin
      exp_l = ((k % (STARVE + 1)) == STARVE);
      applyStimulus(0, 1, 0, SIZE_BYTE, 10'h010, 16'h0000);
      applyStimulus(1, 1, 0, SIZE_WORD, 10'h010, 16'h0000);
      if (push_last || k != n - 1) begin
        if (exp_l) expectResp(1, 1, 0, 16'hBE5A);
        else       expectResp(0, 1, 0, 16'h00BE);
      end
      sample();
      checkOutput("l_gnt_arb", bus.l_gnt, exp_l);
      checkOutput("c_gnt_arb", bus.c_gnt, !exp_l);
      nextCycle();
    end
  endtask

  // Monitor: pops the entry due this cycle; any response with nothing due is an error.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.is_l) begin
        checkOutput("l_rvalid", bus.l_rvalid, e.rvalid);
        checkOutput("l_err", bus.l_err, e.err);
        if (e.rvalid) checkOutput("l_rdata", bus.l_rdata, e.rdata);
        checkOutput("c_quiet", {bus.c_rvalid, bus.c_err}, 2'b00);
      end else begin
        checkOutput("c_rvalid", bus.c_rvalid, e.rvalid);
        checkOutput("c_err", bus.c_err, e.err);
        if (e.rvalid) checkOutput("c_rdata", bus.c_rdata, e.rdata);
        checkOutput("l_quiet", {bus.l_rvalid, bus.l_err}, 2'b00);
      end
    end else if (bus.c_rvalid || bus.l_rvalid || bus.c_err || bus.l_err) begin
      checkOutput("unexpected_resp", {bus.c_rvalid, bus.c_err, bus.l_rvalid, bus.l_err}, 4'b0000);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 1, 0, SIZE_WORD, 10'h010, 16'h0000);
    applyStimulus(1, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;

    // Reset state, with a CPU request pending that must not be granted.
    sample();
    checkOutput("rst_c_gnt", bus.c_gnt, 1'b0);
    checkOutput("rst_l_gnt", bus.l_gnt, 1'b0);
    checkOutput("rst_b_en", bus.b_en, 1'b0);
    checkOutput("rst_b_we", {bus.b_we_h, bus.b_we_l}, 2'b00);
    checkOutput("rst_rvalid", {bus.c_rvalid, bus.l_rvalid}, 2'b00);
    checkOutput("rst_err", {bus.c_err, bus.l_err}, 2'b00);
    checkOutput("rst_c_rdata", bus.c_rdata, 16'h0000);
    checkOutput("rst_l_rdata", bus.l_rdata, 16'h0000);
    nextCycle();
    rst = 1'b0;

    // C word store BEEF to 0x010.
    applyStimulus(0, 1, 1, SIZE_WORD, 10'h010, 16'hBEEF);
    sample();
    checkOutput("st_c_gnt", bus.c_gnt, 1'b1);
    checkOutput("st_b_en", bus.b_en, 1'b1);
    checkOutput("st_b_we", {bus.b_we_h, bus.b_we_l}, 2'b11);
    checkOutput("st_din", {bus.b_din_h, bus.b_din_l}, 16'hBEEF);
    checkOutput("st_b_addr", 16'(bus.b_addr), 16'h0008);
    nextCycle();

    // C word load 0x010 right behind the store.
    applyStimulus(0, 1, 0, SIZE_WORD, 10'h010, 16'h0000);
    expectResp(0, 1, 0, 16'hBEEF);
    sample();
    checkOutput("ld_c_gnt", bus.c_gnt, 1'b1);
    checkOutput("ld_b_we", {bus.b_we_h, bus.b_we_l}, 2'b00);
    nextCycle();

    // C byte store 5A to odd byte 0x011.
    applyStimulus(0, 1, 1, SIZE_BYTE, 10'h011, 16'h005A);
    sample();
    checkOutput("sb_b_we", {bus.b_we_h, bus.b_we_l}, 2'b01);
    checkOutput("sb_din_l", bus.b_din_l, 8'h5A);
    nextCycle();

    applyStimulus(0, 1, 0, SIZE_BYTE, 10'h010, 16'h0000);
    expectResp(0, 1, 0, 16'h00BE);
    sample();
    nextCycle();

    applyStimulus(0, 1, 0, SIZE_BYTE, 10'h011, 16'h0000);
    expectResp(0, 1, 0, 16'h005A);
    sample();
    nextCycle();

    applyStimulus(0, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    sample();
    checkOutput("mem_h8", mem_h[8], 8'hBE);
    checkOutput("mem_l8", mem_l[8], 8'h5A);
    checkOutput("idle_b_en", bus.b_en, 1'b0);
    nextCycle();

    // L misaligned word load at 0x003.
    applyStimulus(1, 1, 0, SIZE_WORD, 10'h003, 16'h0000);
    expectResp(1, 1, 1, 16'h0000);
    sample();
    checkOutput("mis_l_gnt", bus.l_gnt, 1'b1);
    checkOutput("mis_b_en", bus.b_en, 1'b0);
    nextCycle();

    // L byte store 77 to even byte 0x020, then L word load of it.
    applyStimulus(1, 1, 1, SIZE_BYTE, 10'h020, 16'h1277);
    sample();
    checkOutput("lsb_b_we", {bus.b_we_h, bus.b_we_l}, 2'b10);
    checkOutput("lsb_din_h", bus.b_din_h, 8'h77);
    checkOutput("lsb_b_addr", 16'(bus.b_addr), 16'h0010);
    nextCycle();

    applyStimulus(1, 1, 0, SIZE_WORD, 10'h020, 16'h0000);
    expectResp(1, 1, 0, 16'h7700);
    sample();
    nextCycle();

    applyStimulus(1, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    sample();
`ifdef DMEM_ARB_STATS_EN
    snap_c = stat_c_grants;
    snap_l = stat_l_grants;
    snap_x = stat_conflicts;
`endif
    nextCycle();

    conflictCycles(10, 1'b1);

    applyStimulus(0, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    applyStimulus(1, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    sample();
`ifdef DMEM_ARB_STATS_EN
    checkOutput("stat_conflicts", stat_conflicts - snap_x, 16'd10);
    checkOutput("stat_c_grants", stat_c_grants - snap_c, 16'd8);
    checkOutput("stat_l_grants", stat_l_grants - snap_l, 16'd2);
`endif
    nextCycle();

    // C misaligned word store: error flag, no load response.
    applyStimulus(0, 1, 1, SIZE_WORD, 10'h011, 16'hDEAD);
    expectResp(0, 0, 1, 16'h0000);
    sample();
    checkOutput("mst_c_gnt", bus.c_gnt, 1'b1);
    checkOutput("mst_b_en", bus.b_en, 1'b0);
    nextCycle();

    // Starve L up to promotion, then reset while a C load response is pending.
    conflictCycles(STARVE, 1'b0);
    rst = 1'b1;
    sample();
    checkOutput("mid_rst_gnt", {bus.c_gnt, bus.l_gnt}, 2'b00);
    checkOutput("mid_rst_b_en", bus.b_en, 1'b0);
    checkOutput("mid_rst_c_rvalid", bus.c_rvalid, 1'b0);
    checkOutput("mid_rst_c_rdata", bus.c_rdata, 16'h0000);
    nextCycle();
    rst = 1'b0;
    conflictCycles(STARVE + 1, 1'b1);

    applyStimulus(0, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    applyStimulus(1, 0, 0, SIZE_BYTE, 10'h000, 16'h0000);
    repeat (3) begin
      sample();
      nextCycle();
    end
    checkOutput("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
